// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit
//   Decode stage of a RISC-V style pipeline. Decodes the opcode of the
//   incoming instruction into main-control signals. It also extracts the
//   rd/rs1/rs2 fields. All of this is registered with one cycle of latency.
//   When built with PCU_HAZARD_EN defined, it also detects load-use hazards.
//
//   Per-edge priority: rst > flush (bubble) > stall_in (hold) >
//   hazard_stall (bubble) > in_valid (issue) > bubble.
//
// Parameters
//   XLEN  instruction word width (>= 32, only bits [31:0] are decoded)
//   RA_W  width of the register-address outputs
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid, code  instruction from fetch
//   stall_in        downstream hold request
//   flush           squash stage contents
//   RegWrite .. Jump, out_valid, illegal, rd_out/rs1_out/rs2_out
//                   registered decode outputs
//   hazard_stall    combinational load-use stall back to fetch
//
// Configuration macro: PCU_HAZARD_EN (undefined: hazard_stall tied to 0)
module pipelined_control_unit #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned RA_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [XLEN-1:0] code,
   input  logic            stall_in,
   input  logic            flush,
   output logic            RegWrite,
   output logic            MemtoReg,
   output logic            ALUSrc,
   output logic [1:0]      ALUOp,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            Branch,
   output logic            Jump,
   output logic            out_valid,
   output logic            illegal,
   output logic [RA_W-1:0] rd_out,
   output logic [RA_W-1:0] rs1_out,
   output logic [RA_W-1:0] rs2_out,
   output logic            hazard_stall
);

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpI      = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;

   typedef struct packed {
      logic [8:0]      ctrl;   // {RegWrite,MemtoReg,ALUSrc,ALUOp,MemRead,MemWrite,Branch,Jump}
      logic            valid;
      logic            illegal;
      logic [RA_W-1:0] rd;
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
   } stage_t;

   logic [6:0] opcode;
   logic [8:0] dec_ctrl;
   logic       dec_legal;
   stage_t     issue;
   stage_t     stage_d;
   stage_t     stage_q;

   // funct fields and any bits above 31 never influence the decode
   logic       unused_code_bits;
   assign unused_code_bits = ^code;

   assign opcode = code[6:0];

   always_comb begin
      dec_ctrl  = '0;
      dec_legal = 1'b1;
      case (opcode)
         OpR:      dec_ctrl = 9'b1_0_0_10_0_0_0_0;
         OpI:      dec_ctrl = 9'b1_0_1_11_0_0_0_0;
         OpLoad:   dec_ctrl = 9'b1_1_1_00_1_0_0_0;
         OpStore:  dec_ctrl = 9'b0_0_1_00_0_1_0_0;
         OpBranch: dec_ctrl = 9'b0_0_0_01_0_0_1_0;
         OpJal:    dec_ctrl = 9'b1_0_0_00_0_0_0_1;
         OpJalr:   dec_ctrl = 9'b1_0_1_00_0_0_0_1;
         OpLui:    dec_ctrl = 9'b1_0_1_00_0_0_0_0;
         default:  dec_legal = 1'b0;
      endcase
      // writes to x0 are dropped, but the instruction still issues
      if (code[11:7] == 5'd0) dec_ctrl[8] = 1'b0;
   end

   // Illegal opcodes issue as a bubble carrying only the illegal flag
   always_comb begin
      issue = '0;
      if (dec_legal) begin
         issue.ctrl  = dec_ctrl;
         issue.valid = 1'b1;
         issue.rd    = RA_W'(code[11:7]);
         issue.rs1   = RA_W'(code[19:15]);
         issue.rs2   = RA_W'(code[24:20]);
      end else begin
         issue.illegal = 1'b1;
      end
   end

`ifdef PCU_HAZARD_EN
   logic uses_rs2;
   assign uses_rs2 = (opcode == OpR) | (opcode == OpStore) | (opcode == OpBranch);

   // Load in the output register whose rd feeds the instruction at fetch
   assign hazard_stall = in_valid & out_valid & MemRead & (rd_out != '0) &
                         ((rd_out == RA_W'(code[19:15])) |
                          (uses_rs2 & (rd_out == RA_W'(code[24:20]))));
`else
   assign hazard_stall = 1'b0;
`endif

   always_comb begin
      stage_d = '0;
      if (flush) begin
         stage_d = '0;
      end else if (stall_in) begin
         stage_d = stage_q;
      end else if (hazard_stall) begin
         stage_d = '0;
      end else if (in_valid) begin
         stage_d = issue;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) stage_q <= '0;
      else     stage_q <= stage_d;
   end

   assign {RegWrite, MemtoReg, ALUSrc, ALUOp, MemRead, MemWrite, Branch, Jump} = stage_q.ctrl;
   assign out_valid = stage_q.valid;
   assign illegal   = stage_q.illegal;
   assign rd_out    = stage_q.rd;
   assign rs1_out   = stage_q.rs1;
   assign rs2_out   = stage_q.rs2;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: directed scenarios followed by
// randomized traffic, all compared against an opcode-table reference model.
module tb_pipelined_control_unit;

`ifdef PCU_HAZARD_EN
   localparam bit HazEn = 1'b1;
`else
   localparam bit HazEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] code = '0;
   logic        stall_in = 1'b0;
   logic        flush = 1'b0;
   logic        RegWrite, MemtoReg, ALUSrc, MemRead, MemWrite, Branch, Jump;
   logic [1:0]  ALUOp;
   logic        out_valid, illegal, hazard_stall;
   logic [4:0]  rd_out, rs1_out, rs2_out;

   pipelined_control_unit #(.XLEN(32), .RA_W(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .code         (code),
      .stall_in     (stall_in),
      .flush        (flush),
      .RegWrite     (RegWrite),
      .MemtoReg     (MemtoReg),
      .ALUSrc       (ALUSrc),
      .ALUOp        (ALUOp),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .Branch       (Branch),
      .Jump         (Jump),
      .out_valid    (out_valid),
      .illegal      (illegal),
      .rd_out       (rd_out),
      .rs1_out      (rs1_out),
      .rs2_out      (rs2_out),
      .hazard_stall (hazard_stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] op;
      logic [8:0] ctrl;  // {RegWrite,MemtoReg,ALUSrc,ALUOp,MemRead,MemWrite,Branch,Jump}
      bit         rs2;
   } ent_t;

   ent_t tbl[8];

   // Reference state: what the output register should hold
   logic [8:0] m_ctrl;
   logic       m_ov, m_ill;
   logic [4:0] m_rd, m_rs1, m_rs2;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit lookup(input logic [6:0] op, output logic [8:0] ctrl, output bit u2);
      bit found = 1'b0;
      ctrl = '0;
      u2   = 1'b0;
      foreach (tbl[i]) begin
         if (tbl[i].op == op) begin
            ctrl  = tbl[i].ctrl;
            u2    = tbl[i].rs2;
            found = 1'b1;
         end
      end
      return found;
   endfunction

   task automatic m_clear();
      m_ctrl = '0; m_ov = 1'b0; m_ill = 1'b0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
   endtask

   // One clock: drive inputs, check hazard_stall, clock, check registered outputs
   task automatic step(input bit r, input bit v, input logic [31:0] c, input bit s, input bit f,
                       input string tag);
      logic [8:0] ctrl;
      bit         u2, legal, hz;
      @(negedge clk);
      rst = r; in_valid = v; code = c; stall_in = s; flush = f;
      #1;
      legal = lookup(c[6:0], ctrl, u2);
      hz = HazEn && v && m_ov && m_ctrl[3] && (m_rd != 0) &&
           ((m_rd == c[19:15]) || (u2 && (m_rd == c[24:20])));
      chk({tag, ".haz"}, 32'(hazard_stall), 32'(hz));
      @(posedge clk);
      if (r || f) m_clear();
      else if (s) begin end
      else if (hz || !v) m_clear();
      else if (!legal) begin
         m_clear();
         m_ill = 1'b1;
      end else begin
         m_ctrl = ctrl;
         if (c[11:7] == 5'd0) m_ctrl[8] = 1'b0;
         m_ov  = 1'b1;
         m_ill = 1'b0;
         m_rd  = c[11:7];
         m_rs1 = c[19:15];
         m_rs2 = c[24:20];
      end
      #1;
      chk({tag, ".out"},
          32'({RegWrite, MemtoReg, ALUSrc, ALUOp, MemRead, MemWrite, Branch, Jump,
               out_valid, illegal, rd_out, rs1_out, rs2_out}),
          32'({m_ctrl, m_ov, m_ill, m_rd, m_rs1, m_rs2}));
   endtask

   localparam logic [31:0] Addi = 32'h00500093;
   localparam logic [31:0] Lw   = 32'h0000A103;
   localparam logic [31:0] Add  = 32'h001101B3;
   localparam logic [31:0] AddX0 = 32'h00208033;

   logic [31:0] rc;
   int          k;

   initial begin
      tbl[0] = '{7'b0110011, 9'b1_0_0_10_0_0_0_0, 1'b1};
      tbl[1] = '{7'b0010011, 9'b1_0_1_11_0_0_0_0, 1'b0};
      tbl[2] = '{7'b0000011, 9'b1_1_1_00_1_0_0_0, 1'b0};
      tbl[3] = '{7'b0100011, 9'b0_0_1_00_0_1_0_0, 1'b1};
      tbl[4] = '{7'b1100011, 9'b0_0_0_01_0_0_1_0, 1'b1};
      tbl[5] = '{7'b1101111, 9'b1_0_0_00_0_0_0_1, 1'b0};
      tbl[6] = '{7'b1100111, 9'b1_0_1_00_0_0_0_1, 1'b0};
      tbl[7] = '{7'b0110111, 9'b1_0_1_00_0_0_0_0, 1'b0};
      m_clear();

      // reset
      step(1, 0, 32'h0, 0, 0, "reset");
      chk("reset.ov", 32'(out_valid), 32'd0);

      // addi x1, x0, 5
      step(0, 1, Addi, 0, 0, "issue");
      chk("issue.rw", 32'(RegWrite), 32'd1);
      chk("issue.alusrc", 32'(ALUSrc), 32'd1);
      chk("issue.aluop", 32'(ALUOp), 32'd3);
      chk("issue.rd", 32'(rd_out), 32'd1);
      chk("issue.ov", 32'(out_valid), 32'd1);

      // x0 destination
      step(0, 1, AddX0, 0, 0, "x0");
      chk("x0.ov", 32'(out_valid), 32'd1);
      chk("x0.rw", 32'(RegWrite), 32'd0);

      // load-use
      step(0, 1, Lw, 0, 0, "lu.load");
      step(0, 1, Add, 0, 0, "lu.add1");
      step(0, 1, Add, 0, 0, "lu.add2");
      chk("lu.rs1", 32'(rs1_out), 32'd2);
      chk("lu.rs2", 32'(rs2_out), 32'd1);
      chk("lu.aluop", 32'(ALUOp), 32'd2);
      chk("lu.ov", 32'(out_valid), 32'd1);

      // flush beats stall and hazard
      step(0, 1, Lw, 0, 0, "pri.load");
      step(0, 1, Add, 1, 1, "pri.fl");
      chk("pri.ov", 32'(out_valid), 32'd0);

      // illegal opcode lasts one cycle
      step(0, 1, 32'h0000007F, 0, 0, "ill");
      chk("ill.flag", 32'(illegal), 32'd1);
      chk("ill.ov", 32'(out_valid), 32'd0);
      step(0, 0, 32'h0, 0, 0, "ill.after");
      chk("ill.clr", 32'(illegal), 32'd0);

      // reset while a load is held under stall
      step(0, 1, Lw, 0, 0, "rm.load");
      step(0, 1, Add, 1, 0, "rm.hold");
      chk("rm.memread", 32'(MemRead), 32'd1);
      step(1, 1, Add, 1, 0, "rm.rst");
      chk("rm.ov", 32'(out_valid), 32'd0);
      chk("rm.rd", 32'(rd_out), 32'd0);
      step(0, 1, Add, 0, 0, "rm.post");

      // randomized traffic, small register range to provoke hazards
      for (int i = 0; i < 500; i++) begin
         k  = int'($urandom_range(0, 11));
         rc = $urandom;
         if (k < 8) rc[6:0] = tbl[k].op;
         else if (k >= 10) rc[6:0] = tbl[2].op;
         rc[11:7]  = 5'($urandom_range(0, 3));
         rc[19:15] = 5'($urandom_range(0, 3));
         rc[24:20] = 5'($urandom_range(0, 3));
         step($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, rc,
              $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
